// File: rtl/pll_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pll_cfg_pkg : shared types, reconfig register map and PLL profile table
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pll_cfg_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MODE_WR   = 3'd1,
    TBL_WR    = 3'd2,
    START_WR  = 3'd3,
    SETTLE    = 3'd4,
    WAIT_LOCK = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_N     = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;

  localparam logic [DATA_W-1:0] DATA_WAITREQ_MODE = 32'h0000_0000;
  localparam logic [DATA_W-1:0] DATA_START        = 32'h0000_0001;

  // Rows are profiles, columns are N, M, C0, C1 (48 MHz reference).
  // Profile 0 = 144/144 MHz (power-on), 1 = 100/100, 2 = 200/200, 3 = 50/50.
  localparam logic [DATA_W-1:0] PROFILE_TBL [4][4] = '{
    '{32'h0001_0000, 32'h0000_0606, 32'h0000_0202, 32'h0004_0202},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0000_0303, 32'h0004_0303},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0002_0201, 32'h0006_0201},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0000_0606, 32'h0004_0606}
  };

  function automatic logic [ADDR_W-1:0] tbl_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    tbl_addr = ADDR_N;
      2'd1:    tbl_addr = ADDR_M;
      default: tbl_addr = ADDR_C;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_cfg_avm_wr.sv
// ----------------------------------------------------------------------------
// pll_cfg_avm_wr : single Avalon-MM write, held until waitrequest drops
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pll_cfg_avm_wr
  import pll_cfg_pkg::*;
(
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              waitrequest,
  output logic              ack,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic [DATA_W-1:0] mgmt_writedata,
  output logic              mgmt_write
);

  // Bus is zeroed whenever no write is requested.
  assign mgmt_write     = req;
  assign mgmt_address   = req ? addr : '0;
  assign mgmt_writedata = req ? data : '0;
  assign ack            = req & ~waitrequest;

endmodule

`default_nettype wire

// File: rtl/pll_cfg_seq.sv
// ----------------------------------------------------------------------------
// pll_cfg_seq : PLL reconfiguration sequencer (profile write, settle, lock wait)
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              locked,
  input  logic              mgmt_waitrequest,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic [DATA_W-1:0] mgmt_writedata,
  output logic              mgmt_write,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  state_t      state;
  logic [1:0]  mode_q;
  logic [1:0]  idx;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;

  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign wr_req = (state == MODE_WR) || (state == TBL_WR) || (state == START_WR);

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (state)
      MODE_WR: begin
        wr_addr = ADDR_MODE;
        wr_data = DATA_WAITREQ_MODE;
      end
      TBL_WR: begin
        wr_addr = tbl_addr(idx);
        wr_data = PROFILE_TBL[mode_q][idx];
      end
      START_WR: begin
        wr_addr = ADDR_START;
        wr_data = DATA_START;
      end
      default: ;
    endcase
  end

  pll_cfg_avm_wr u_avm_wr (
    .req            (wr_req),
    .addr           (wr_addr),
    .data           (wr_data),
    .waitrequest    (mgmt_waitrequest),
    .ack            (wr_ack),
    .mgmt_address   (mgmt_address),
    .mgmt_writedata (mgmt_writedata),
    .mgmt_write     (mgmt_write)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            mode_q <= mode;
            idx    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
            state  <= MODE_WR;
          end
        end
        MODE_WR: begin
          if (wr_ack) state <= TBL_WR;
        end
        TBL_WR: begin
          // Index wraps back to 0 after C1, ready for the next sequence.
          if (wr_ack) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= START_WR;
          end
        end
        START_WR: begin
          if (wr_ack) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            tmo_cnt <= '0;
            state   <= WAIT_LOCK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock wins over a timeout landing on the same cycle.
          if (locked) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end else if (tmo_cnt != {TW{1'b1}}) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_pll_cfg_seq : directed self-checking bench for pll_cfg_seq
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pll_cfg_seq;

  localparam int LT = 100;
  localparam int SC = 16;

  logic        refclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        busy, done, error;

  always #5 refclk = ~refclk;

  pll_cfg_seq #(.LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC)) dut (
    .refclk           (refclk),
    .rst_n            (rst_n),
    .start            (start),
    .mode             (mode),
    .locked           (locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_write       (mgmt_write),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [5:0]  wa [8];
  logic [31:0] wd [8];
  int          wc [8];
  int          nw;
  int          m_cyc;
  bit          m_unstable;
  logic [31:0] m_data0;

  logic [31:0] prof [4][4] = '{
    '{32'h0001_0000, 32'h0000_0606, 32'h0000_0202, 32'h0004_0202},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0000_0303, 32'h0004_0303},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0002_0201, 32'h0006_0201},
    '{32'h0000_0101, 32'h0002_0D0C, 32'h0000_0606, 32'h0004_0606}
  };
  logic [5:0] exp_a [6] = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h02};

  function automatic logic [31:0] exp_d(int md, int i);
    if (i == 0) return 32'h0;
    if (i == 5) return 32'h1;
    return prof[md][i-1];
  endfunction

  // Watches the bus each cycle, optionally stalling one write or injecting a start.
  task automatic collect(int stall_idx, int stall_len, int inject_cyc, int stop_cyc, int max_cyc);
    int left = stall_len;
    nw = 0; m_cyc = 0; m_unstable = 0; m_data0 = '0;
    for (int cyc = 1; cyc <= max_cyc && nw < 6; cyc++) begin
      @(negedge refclk);
      start = 1'b0;
      mgmt_waitrequest = 1'b0;
      if (cyc == inject_cyc) begin start = 1'b1; mode = 2'd3; end
      if (mgmt_write) begin
        if (mgmt_address == 6'h04) begin
          if (m_cyc == 0) m_data0 = mgmt_writedata;
          else if (mgmt_writedata !== m_data0) m_unstable = 1;
          m_cyc++;
        end
        if (nw == stall_idx && left > 0) begin
          mgmt_waitrequest = 1'b1;
          left--;
        end else begin
          wa[nw] = mgmt_address; wd[nw] = mgmt_writedata; wc[nw] = cyc; nw++;
        end
      end
      if (cyc == stop_cyc) break;
    end
  endtask

  task automatic wait_end(int lock_at, int bound, output int k);
    k = 0;
    do begin
      @(negedge refclk);
      k++;
      if (k == lock_at) locked = 1'b1;
    end while (!(done || error) && k < bound);
  endtask

  task automatic issue_start(logic [1:0] m);
    start = 1'b1;
    mode = m;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    n_total++; if (mgmt_write !== 1'b0) $display("FAIL reset_write got=%b want=0", mgmt_write); else n_pass++;
    n_total++; if (mgmt_address !== 6'h0) $display("FAIL reset_addr got=%h want=00", mgmt_address); else n_pass++;
    n_total++; if (mgmt_writedata !== 32'h0) $display("FAIL reset_data got=%h want=0", mgmt_writedata); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status got=%b want=000", {busy, done, error}); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int k;
    locked = 1'b1;
    issue_start(2'd0);
    collect(-1, 0, 0, 0, 40);
    n_total++; if (nw !== 6) $display("FAIL basic_count got=%0d want=6", nw); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (wa[i] !== exp_a[i]) $display("FAIL basic_addr%0d got=%h want=%h", i, wa[i], exp_a[i]); else n_pass++;
      n_total++; if (wd[i] !== exp_d(0, i)) $display("FAIL basic_data%0d got=%h want=%h", i, wd[i], exp_d(0, i)); else n_pass++;
      n_total++; if (wc[i] !== i + 1) $display("FAIL basic_cycle%0d got=%0d want=%0d", i, wc[i], i + 1); else n_pass++;
    end
    wait_end(0, 200, k);
    n_total++; if (k !== 18) $display("FAIL basic_done_latency got=%0d want=18", k); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b010) $display("FAIL basic_status got=%b want=010", {busy, done, error}); else n_pass++;
  endtask

  task automatic test_waitrequest;
    int k;
    locked = 1'b1;
    issue_start(2'd1);
    collect(2, 3, 0, 0, 40);
    n_total++; if (nw !== 6) $display("FAIL ws_count got=%0d want=6", nw); else n_pass++;
    n_total++; if (m_cyc !== 4) $display("FAIL ws_m_hold got=%0d want=4", m_cyc); else n_pass++;
    n_total++; if (m_unstable !== 1'b0) $display("FAIL ws_m_stable got=%b want=0", m_unstable); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (wa[i] !== exp_a[i]) $display("FAIL ws_addr%0d got=%h want=%h", i, wa[i], exp_a[i]); else n_pass++;
      n_total++; if (wd[i] !== exp_d(1, i)) $display("FAIL ws_data%0d got=%h want=%h", i, wd[i], exp_d(1, i)); else n_pass++;
    end
    n_total++; if (wc[5] !== 9) $display("FAIL ws_last_cycle got=%0d want=9", wc[5]); else n_pass++;
    wait_end(0, 200, k);
    n_total++; if (done !== 1'b1) $display("FAIL ws_done got=%b want=1", done); else n_pass++;
  endtask

  task automatic test_timeout;
    int k;
    locked = 1'b0;
    issue_start(2'd2);
    collect(-1, 0, 0, 0, 40);
    n_total++; if (busy !== 1'b1) $display("FAIL to_busy_settle got=%b want=1", busy); else n_pass++;
    wait_end(0, 300, k);
    n_total++; if (k !== 117) $display("FAIL to_latency got=%0d want=117", k); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b001) $display("FAIL to_status got=%b want=001", {busy, done, error}); else n_pass++;
  endtask

  task automatic test_lock_at_expiry;
    int k;
    locked = 1'b0;
    issue_start(2'd0);
    collect(-1, 0, 0, 0, 40);
    n_total++; if (error !== 1'b0) $display("FAIL exp_error_cleared got=%b want=0", error); else n_pass++;
    wait_end(116, 300, k);
    n_total++; if (k !== 117) $display("FAIL exp_latency got=%0d want=117", k); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b010) $display("FAIL exp_status got=%b want=010", {busy, done, error}); else n_pass++;
  endtask

  task automatic test_ignored_start;
    int k;
    locked = 1'b1;
    issue_start(2'd1);
    collect(-1, 0, 3, 0, 40);
    n_total++; if (nw !== 6) $display("FAIL ign_count got=%0d want=6", nw); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      n_total++; if (wd[i] !== exp_d(1, i)) $display("FAIL ign_data%0d got=%h want=%h", i, wd[i], exp_d(1, i)); else n_pass++;
    end
    wait_end(0, 200, k);
    n_total++; if (k !== 18) $display("FAIL ign_done_latency got=%0d want=18", k); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    int k;
    locked = 1'b1;
    issue_start(2'd2);
    collect(-1, 0, 0, 4, 40);
    n_total++; if (mgmt_address !== 6'h05) $display("FAIL rmw_pre_addr got=%h want=05", mgmt_address); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (mgmt_write !== 1'b0) $display("FAIL rmw_write got=%b want=0", mgmt_write); else n_pass++;
    n_total++; if ({mgmt_address, mgmt_writedata} !== 38'h0) $display("FAIL rmw_bus got=%h want=0", {mgmt_address, mgmt_writedata}); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b000) $display("FAIL rmw_status got=%b want=000", {busy, done, error}); else n_pass++;
    @(negedge refclk);
    rst_n = 1'b1;
    issue_start(2'd0);
    collect(-1, 0, 0, 0, 40);
    n_total++; if (nw !== 6) $display("FAIL rmw_count got=%0d want=6", nw); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (wa[i] !== exp_a[i]) $display("FAIL rmw_addr%0d got=%h want=%h", i, wa[i], exp_a[i]); else n_pass++;
      n_total++; if (wd[i] !== exp_d(0, i)) $display("FAIL rmw_data%0d got=%h want=%h", i, wd[i], exp_d(0, i)); else n_pass++;
    end
    wait_end(0, 200, k);
    n_total++; if (k !== 18) $display("FAIL rmw_done_latency got=%0d want=18", k); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitrequest();
    test_timeout();
    test_lock_at_expiry();
    test_ignored_start();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
